// File: rtl/sram_responder.sv
// Word-addressed SRAM slave with a request/response handshake.
// The wait-state count is fixed at build time, and out-of-range or misaligned accesses report err.
module sram_responder #(
    parameter int          AW       = 10,
    parameter logic [31:0] BASE     = 32'h1c000000,
    parameter int          WAIT_CYC = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        err
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int         DEPTH    = 1 << AW;
    localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_q, wr_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic        do_op;
    logic        op_wr;
    logic [31:0] op_addr;
    logic [3:0]  op_wstrb;
    logic [31:0] op_wdata;
    logic [31:0] op_off;
    logic        op_fault;
    logic [AW-1:0] op_idx;
    logic        mem_we;
    logic [31:0] mem_rd;

    assign accept = req & addr_ok;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (accept) begin
                    state_d = (WAIT_CYC > 0) ? S_WAIT : S_RESP;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        addr_ok = (state_q != S_WAIT);
        data_ok = (state_q == S_RESP);
    end

    // With no wait states the access happens on the acceptance edge itself,
    // so the operation is taken straight from the inputs in that case.
    always_comb begin
        wr_d    = accept ? wr    : wr_q;
        addr_d  = accept ? addr  : addr_q;
        wstrb_d = accept ? wstrb : wstrb_q;
        wdata_d = accept ? wdata : wdata_q;
        op_wr    = wr_d;
        op_addr  = addr_d;
        op_wstrb = wstrb_d;
        op_wdata = wdata_d;
    end

    assign do_op    = (state_d == S_RESP);
    assign op_off   = op_addr - BASE;
    assign op_fault = (op_addr < BASE) || (op_addr[1:0] != 2'b00) ||
                      ((op_off >> 2) >= 32'(DEPTH));
    assign op_idx   = op_off[AW+1:2];
    assign mem_we   = do_op && op_wr && !op_fault && !reset;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];

        always_ff @(posedge clk) begin
            if (mem_we && op_wstrb[gi]) begin
                lane_mem[op_idx] <= op_wdata[8*gi +: 8];
            end
        end

        assign mem_rd[8*gi +: 8] = lane_mem[op_idx];
    end

    always_comb begin
        rdata_d = rdata_q;
        err_d   = err_q;
        if (do_op) begin
            err_d   = op_fault;
            rdata_d = (op_fault || op_wr) ? 32'd0 : mem_rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q    <= 1'b0;
            addr_q  <= 32'd0;
            wstrb_q <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: one instance with two wait states and one with none.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wstrb;
    logic        addr_ok, data_ok, err;
    logic [31:0] rdata;

    logic        req0, wr0;
    logic [31:0] addr0, wdata0;
    logic [3:0]  wstrb0;
    logic        addr_ok0, data_ok0, err0;
    logic [31:0] rdata0;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_responder #(.AW(10), .BASE(32'h1c000000), .WAIT_CYC(2)) u_dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr), .addr(addr),
        .wstrb(wstrb), .wdata(wdata), .addr_ok(addr_ok), .data_ok(data_ok),
        .rdata(rdata), .err(err)
    );

    sram_responder #(.AW(10), .BASE(32'h1c000000), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req0), .wr(wr0), .addr(addr0),
        .wstrb(wstrb0), .wdata(wdata0), .addr_ok(addr_ok0), .data_ok(data_ok0),
        .rdata(rdata0), .err(err0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One access on the WAIT_CYC=2 instance; lat counts sampled cycles after acceptance.
    task automatic xact(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [31:0] d, output int lat, output logic [31:0] rd,
                        output logic e);
        @(negedge clk);
        req = 1'b1; wr = w; addr = a; wstrb = s; wdata = d;
        lat = 99; rd = 32'hffffffff; e = 1'bx;
        @(posedge clk);
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) req = 1'b0;
            if (data_ok) begin
                lat = n; rd = rdata; e = err;
                break;
            end
        end
        $display("xact wr=%0b addr=%h wstrb=%h wdata=%h -> lat=%0d rdata=%h err=%0b",
                 w, a, s, d, lat, rd, e);
    endtask

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        e;
        int          pulses;
        int          accepts;

        reset = 1'b0;
        req = 0; wr = 0; addr = 0; wstrb = 0; wdata = 0;
        req0 = 0; wr0 = 0; addr0 = 0; wstrb0 = 0; wdata0 = 0;
        #1 reset = 1'b1;
        #2;
        chk("rst_data_ok", 32'(data_ok), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_addr_ok", 32'(addr_ok), 32'd1);
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_addr_ok", 32'(addr_ok), 32'd1);

        // Full write then read back
        xact(1'b1, 32'h1c000010, 4'hf, 32'hdeadbeef, lat, rd, e);
        chk("wr1_lat", 32'(lat), 32'd3);
        chk("wr1_err", 32'(e), 32'd0);
        chk("wr1_rdata", rd, 32'd0);
        xact(1'b0, 32'h1c000010, 4'h0, 32'h0, lat, rd, e);
        chk("rd1_lat", 32'(lat), 32'd3);
        chk("rd1_rdata", rd, 32'hdeadbeef);
        chk("rd1_err", 32'(e), 32'd0);
        @(negedge clk);
        chk("rd1_pulse_end", 32'(data_ok), 32'd0);
        chk("rd1_rdata_hold", rdata, 32'hdeadbeef);

        // Byte-lane merge
        xact(1'b1, 32'h1c000020, 4'hf, 32'h11223344, lat, rd, e);
        xact(1'b1, 32'h1c000020, 4'b0101, 32'haabbccdd, lat, rd, e);
        xact(1'b0, 32'h1c000020, 4'h0, 32'h0, lat, rd, e);
        chk("strb_rdata", rd, 32'h11bb33dd);
        xact(1'b1, 32'h1c000020, 4'h0, 32'hffffffff, lat, rd, e);
        chk("strb0_lat", 32'(lat), 32'd3);
        chk("strb0_err", 32'(e), 32'd0);
        xact(1'b0, 32'h1c000020, 4'h0, 32'h0, lat, rd, e);
        chk("strb0_rdata", rd, 32'h11bb33dd);

        // Faults
        xact(1'b0, 32'h1bfffffc, 4'h0, 32'h0, lat, rd, e);
        chk("flt_below_err", 32'(e), 32'd1);
        chk("flt_below_rdata", rd, 32'd0);
        xact(1'b0, 32'h1c000002, 4'h0, 32'h0, lat, rd, e);
        chk("flt_align_err", 32'(e), 32'd1);
        chk("flt_align_rdata", rd, 32'd0);
        xact(1'b0, 32'h1c001000, 4'h0, 32'h0, lat, rd, e);
        chk("flt_top_err", 32'(e), 32'd1);
        chk("flt_top_rdata", rd, 32'd0);
        xact(1'b0, 32'h1c000ffc, 4'h0, 32'h0, lat, rd, e);
        chk("last_word_err", 32'(e), 32'd0);
        xact(1'b1, 32'h1c001010, 4'hf, 32'h0, lat, rd, e);
        chk("flt_wr_err", 32'(e), 32'd1);
        xact(1'b1, 32'h1bfffff0, 4'hf, 32'h0, lat, rd, e);
        chk("flt_wr2_err", 32'(e), 32'd1);
        xact(1'b0, 32'h1c000010, 4'h0, 32'h0, lat, rd, e);
        chk("flt_mem_kept", rd, 32'hdeadbeef);

        // Held request: four back-to-back reads
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr = 32'h1c000010;
        accepts = 1; pulses = 0;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            $display("held k=%0d addr_ok=%0b data_ok=%0b rdata=%h", k, addr_ok, data_ok, rdata);
            chk($sformatf("held_addr_ok_%0d", k), 32'(addr_ok), 32'((k % 3 == 0) || (k > 12)));
            chk($sformatf("held_data_ok_%0d", k), 32'(data_ok), 32'((k % 3 == 0) && (k <= 12)));
            if (data_ok) begin
                pulses++;
                chk($sformatf("held_rdata_%0d", k), rdata, 32'hdeadbeef);
            end
            if (addr_ok) begin
                if (accepts < 4) accepts++;
                else req = 1'b0;
            end
        end
        chk("held_pulses", 32'(pulses), 32'd4);

        // Zero-wait instance: write then read back-to-back
        @(negedge clk);
        req0 = 1'b1; wr0 = 1'b1; addr0 = 32'h1c000040; wstrb0 = 4'hf; wdata0 = 32'h12345678;
        @(negedge clk);
        $display("w0 write resp data_ok=%0b err=%0b rdata=%h", data_ok0, err0, rdata0);
        chk("w0_wr_data_ok", 32'(data_ok0), 32'd1);
        chk("w0_wr_err", 32'(err0), 32'd0);
        chk("w0_wr_rdata", rdata0, 32'd0);
        wr0 = 1'b0;
        @(negedge clk);
        $display("w0 read resp data_ok=%0b err=%0b rdata=%h", data_ok0, err0, rdata0);
        chk("w0_rd_data_ok", 32'(data_ok0), 32'd1);
        chk("w0_rd_rdata", rdata0, 32'h12345678);
        req0 = 1'b0;
        @(negedge clk);
        chk("w0_idle_data_ok", 32'(data_ok0), 32'd0);

        // Reset during WAIT discards the pending write
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr = 32'h1c000010; wstrb = 4'hf; wdata = 32'h0badf00d;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0; reset = 1'b1;
        #1;
        chk("rst_wait_rdata", rdata, 32'd0);
        chk("rst_wait_addr_ok", 32'(addr_ok), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("rst_wait_no_resp_%0d", k), 32'(data_ok), 32'd0);
        end
        xact(1'b0, 32'h1c000010, 4'h0, 32'h0, lat, rd, e);
        chk("rst_wait_old_value", rd, 32'hdeadbeef);
        chk("rst_wait_old_err", 32'(e), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 Parameter AW, default 10: memory holds 2^AW 32-bit words.
REQ-002 Parameter BASE, default 32'h1c000000: byte address of word 0.
REQ-003 Parameter WAIT_CYC, default 2, legal 0..15: extra wait cycles before each response.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 req  input  1  initiator request valid.
REQ-007 wr  input  1  1 = write, 0 = read; qualified by req.
REQ-008 addr  input  32  byte address; qualified by req.
REQ-009 wstrb  input  4  byte-lane write enables, bit i = wdata[8i+7:8i]; qualified by req & wr.
REQ-010 wdata  input  32  write data; qualified by req & wr.
REQ-011 addr_ok  output  1  request accepted this cycle when req & addr_ok.
REQ-012 data_ok  output  1  one-cycle response pulse.
REQ-013 rdata  output  32  read data; valid when data_ok.
REQ-014 err  output  1  access fault flag; valid when data_ok.

Function
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-016 addr_ok SHALL be high in IDLE and RESP and low in WAIT.
REQ-017 On acceptance (req & addr_ok at an edge), the block SHALL latch wr, addr, wstrb and wdata into internal registers.
REQ-018 On acceptance, the next state SHALL be WAIT with counter = WAIT_CYC-1 if WAIT_CYC>0, else RESP.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0, the next state SHALL be RESP.
REQ-020 data_ok SHALL be high exactly in the RESP cycle, i.e. WAIT_CYC+1 cycles after the acceptance edge.
REQ-021 RESP with a new acceptance SHALL transition per REQ-018 (back-to-back, no bubble).
REQ-022 RESP without a new acceptance SHALL return to IDLE.
REQ-023 The fault condition SHALL be true when addr < BASE, addr[1:0] != 0, or word index ((addr-BASE)>>2) >= 2^AW.
REQ-024 The word index SHALL be computed as a 32-bit unsigned subtract; wrap-around below BASE SHALL be treated as a fault.
REQ-025 Reads and writes SHALL take effect on the edge entering RESP: a read loads rdata from the memory word; a write updates only the bytes whose wstrb bit is set.
REQ-026 A faulting access SHALL set err=1 and rdata=0 with data_ok, and SHALL NOT modify memory.
REQ-027 err SHALL be 0 on every non-faulting response.
REQ-028 A write SHALL drive rdata=0.
REQ-029 A write with wstrb=0 SHALL still produce data_ok with err=0 and leave memory unchanged.
REQ-030 rdata and err SHALL hold their values after data_ok until the next RESP.
REQ-031 A read accepted in the RESP cycle of a write to the same address SHALL return the newly written data.
REQ-032 Inputs SHALL be ignored when addr_ok=0; a held req SHALL be accepted at the next cycle in which addr_ok=1.

Reset
REQ-033 While reset=1, state SHALL be IDLE, counter 0, data_ok=0, err=0 and rdata=0, asynchronously.
REQ-034 In the first cycle after reset deasserts, addr_ok SHALL be 1.
REQ-035 Memory contents SHALL NOT be cleared by reset.
REQ-036 Reset asserted while in WAIT SHALL discard the pending access: no memory write and no data_ok.

Verification
REQ-037 WAIT_CYC=2: write addr=1c000010, wdata=DEADBEEF, wstrb=F -> data_ok 3 cycles later with err=0; then read 1c000010 -> rdata=DEADBEEF, err=0.
REQ-038 Write 11223344 with wstrb=F, then write wdata=AABBCCDD with wstrb=0101b to the same address -> a read returns 11BB33DD.
REQ-039 Read 1bfffffc, read 1c000002, and read BASE+4*1024 -> each returns data_ok with err=1 and rdata=0; memory is unchanged.
REQ-040 req held high for 4 consecutive reads -> addr_ok is low in WAIT cycles, accepts occur in RESP cycles, and 4 data_ok pulses appear spaced WAIT_CYC+1 apart.
REQ-041 WAIT_CYC=0: write then read the same address back-to-back -> data_ok on consecutive cycles, and the read returns the written value.
REQ-042 Reset pulsed 1 cycle after a write is accepted (WAIT_CYC=2) -> no data_ok, outputs return to their reset values, and a subsequent read returns the old value.
